// File: rtl/mips_hazard_scoreboard.sv
// MIPS hazard scoreboard: tracks pending destinations in the post-decode stages
// and produces the decode-stage stall and forwarding selects.
// Optional feature: define MIPS_HAZARD_FWD_EN to enable forwarding (stall only on load-use).
module mips_hazard_scoreboard #(
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid,
  input  logic [REG_AW-1:0]                   id_src1,
  input  logic [REG_AW-1:0]                   id_src2,
  input  logic                                id_src1_used,
  input  logic                                id_src2_used,
  input  logic [REG_AW-1:0]                   id_dest,
  input  logic                                id_dest_wr,
  input  logic                                id_is_load,
  input  logic                                stat_clr,
  output logic                                stall_n,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]     fwd_sel1,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]     fwd_sel2,
  output logic [CNT_W-1:0]                    stall_cnt
);

  localparam int unsigned SEL_W = $clog2(PIPE_DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] dest;
    logic              load;
  } slot_t;

  slot_t             slots [PIPE_DEPTH];
  logic [REG_AW-1:0] src   [2];
  logic              used  [2];
  logic [PIPE_DEPTH-1:0] hit [2];
  logic              push;

  assign src[0]  = id_src1;
  assign src[1]  = id_src2;
  assign used[0] = id_src1_used;
  assign used[1] = id_src2_used;

  // Per-source, per-slot match against pending destinations; r0 never matches
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s] = '0;
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        hit[s][k] = used[s] && (src[s] != '0) && slots[k].vld && (slots[k].dest == src[s]);
      end
    end
  end

`ifdef MIPS_HAZARD_FWD_EN
  logic [SEL_W-1:0] sel [2];

  // Youngest matching slot wins: scan oldest to youngest so the youngest overrides
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      sel[s] = '0;
      for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
        if (hit[s][k]) sel[s] = SEL_W'(k + 1);
      end
    end
  end

  // Only a load result still in EX cannot be forwarded in time
  always_comb begin
    stall_n  = 1'b1;
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (id_valid) begin
      stall_n  = !(slots[0].load && (hit[0][0] || hit[1][0]));
      fwd_sel1 = sel[0];
      fwd_sel2 = sel[1];
    end
  end
`else
  // Without forwarding any pending producer blocks decode until it drains
  always_comb begin
    stall_n  = 1'b1;
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if (id_valid && ((|hit[0]) || (|hit[1]))) stall_n = 1'b0;
  end
`endif

  assign push = id_valid && id_dest_wr && (id_dest != '0) && stall_n;

  // Pipeline shadow: slot 0 takes the issuing instruction or a bubble, older slots shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(PIPE_DEPTH); k++) slots[k] <= '0;
    end else begin
      slots[0] <= push ? slot_t'{vld: 1'b1, dest: id_dest, load: id_is_load} : '0;
      for (int k = 1; k < int'(PIPE_DEPTH); k++) slots[k] <= slots[k-1];
    end
  end

  // Saturating stall-cycle counter; clear has priority over counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (id_valid && !stall_n && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/mips_hazard_scoreboard.md
MIPS_HAZARD_SCOREBOARD -- requirements
Module: mips_hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REG_AW, default 3, register address width (2^REG_AW GPRs, reg 0 hard-wired zero).
REQ-002 SHALL provide parameter PIPE_DEPTH, default 3, number of post-decode stages that hold a pending destination (EX, MEM, WB for the default).
REQ-003 SHALL provide parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 id_valid  input  1  decode stage holds a real instruction.
REQ-007 id_src1 / id_src2  input  REG_AW each  source register numbers.
REQ-008 id_src1_used / id_src2_used  input  1 each  the source is actually read.
REQ-009 id_dest  input  REG_AW  destination register number.
REQ-010 id_dest_wr  input  1  instruction writes id_dest.
REQ-011 id_is_load  input  1  instruction is a load (result late).
REQ-012 stat_clr  input  1  synchronous clear of stall_cnt.
REQ-013 stall_n  output  1  0 = hold IF/ID and inject bubble.
REQ-014 fwd_sel1 / fwd_sel2  output  $clog2(PIPE_DEPTH+1) each  0 = register file, k = result of scoreboard slot k-1.
REQ-015 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-016 SHALL hold a shift register of PIPE_DEPTH slots {vld, dest, load}; slot 0 is youngest (EX).
REQ-017 Every cycle, slot k SHALL move to slot k+1; slot PIPE_DEPTH-1 SHALL be discarded (written back).
REQ-018 Slot 0 SHALL load {1, id_dest, id_is_load} when id_valid & id_dest_wr & id_dest!=0 & stall_n; otherwise {0, 0, 0} (bubble).
REQ-019 A source SHALL match slot k when it is used, is non-zero, and equals slot k dest with slot k vld=1.
REQ-020 Register 0 SHALL never match, never stall, and always yield fwd_sel=0.
REQ-021 With id_valid=0, stall_n SHALL be 1 and fwd_sel1/fwd_sel2 SHALL be 0.
REQ-022 stall_n and fwd_sel SHALL be combinational from current inputs and slot state (zero-cycle latency).
REQ-023 For multiple matching slots, the youngest (lowest k) SHALL have priority.
REQ-024 A stall SHALL last exactly until the blocking slot drains; no extra cycles.
REQ-025 An instruction whose dest equals its own src SHALL not self-match (the match check precedes the slot-0 load).
REQ-026 stall_cnt SHALL increment by 1 each cycle with id_valid=1 and stall_n=0, and saturate at 2^CNT_W-1.
REQ-027 stat_clr SHALL zero stall_cnt; when asserted with a stall cycle, clear wins.

Reset
REQ-028 rst=0 SHALL asynchronously clear all slot vld/dest/load bits and stall_cnt.
REQ-029 During and immediately after reset, stall_n SHALL be 1 and fwd_sel1/fwd_sel2 0 (empty scoreboard).
REQ-030 Reset asserted mid-stall SHALL drop the stall in the same cycle; no pending state SHALL survive.

Configuration
REQ-031 Macro MIPS_HAZARD_FWD_EN SHALL select forwarding.
REQ-032 Without MIPS_HAZARD_FWD_EN: any source match in any slot SHALL force stall_n=0; fwd_sel1/fwd_sel2 SHALL be constant 0.
REQ-033 With MIPS_HAZARD_FWD_EN: stall_n=0 only when a source matches slot 0 with load=1 (load-use); otherwise fwd_selN = k+1 of the youngest matching slot k.
REQ-034 With MIPS_HAZARD_FWD_EN, a load-use stall SHALL last exactly 1 cycle, after which fwd_sel=2.

Verification
REQ-035 Without FWD: ADD r3 writes, next ADD reads r3 -> stall_n=0 for 3 cycles (PIPE_DEPTH=3), then 1; stall_cnt=3.
REQ-036 With FWD: same sequence -> stall_n stays 1, fwd_sel1=1; one instruction later the reader gets fwd_sel1=2.
REQ-037 With FWD: LW r2 then ADD reading r2 -> stall_n=0 one cycle, then stall_n=1 with fwd_sel=2.
REQ-038 Writer to r0 then reader of r0 -> no stall and fwd_sel=0 in both configurations.
REQ-039 CNT_W=4, force 20 stall cycles -> stall_cnt=15; stat_clr pulse -> 0 next cycle.
REQ-040 Assert rst mid-stall -> stall_n=1 immediately, stall_cnt=0, and a following reader of the old dest does not stall.
